// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single memory port between instruction fetch (IF) and load/store (LS).
// One transaction in flight; LS has priority, bounded by a starvation counter that protects IF.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_be,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int BW = DW/8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } mreq_t;

  state_t        state, state_nx;
  mreq_t         req_q, req_nx;
  logic          req_vld_q, req_vld_nx;
  logic          owner_ls, owner_ls_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [DW-1:0] if_rdata_q, ls_rdata_q;
  logic          arb_en, starved, ls_win, if_win, fwd;

  // Arbitration is also gated by reset so no grant escapes while the block is held in reset.
  assign arb_en  = nreset && ((state == IDLE) || (state == WAIT && mem_rvalid));
  assign starved = if_req && (cnt == 4'(STARVE_MAX));
  assign ls_win  = arb_en && ls_req && !starved;
  assign if_win  = arb_en && if_req && !ls_win;
  assign fwd     = (state == WAIT) && mem_rvalid;

  always_comb begin
    state_nx    = state;
    req_nx      = req_q;
    req_vld_nx  = req_vld_q;
    owner_ls_nx = owner_ls;
    cnt_nx      = cnt;
    unique case (state)
      IDLE:    ;
      ISSUE:   if (mem_gnt) begin
                 state_nx   = WAIT;
                 req_vld_nx = 1'b0;
               end
      WAIT:    if (mem_rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (ls_win) begin
      state_nx    = ISSUE;
      req_vld_nx  = 1'b1;
      owner_ls_nx = 1'b1;
      req_nx      = '{we: ls_we, addr: ls_addr, wdata: ls_wdata, be: ls_be};
      cnt_nx      = !if_req ? 4'd0 : starved ? cnt : cnt + 4'd1;
    end else if (if_win) begin
      state_nx    = ISSUE;
      req_vld_nx  = 1'b1;
      owner_ls_nx = 1'b0;
      req_nx      = '{we: 1'b0, addr: if_addr, wdata: '0, be: '1};
      cnt_nx      = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      req_q      <= '0;
      req_vld_q  <= 1'b0;
      owner_ls   <= 1'b0;
      cnt        <= 4'd0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state     <= state_nx;
      req_q     <= req_nx;
      req_vld_q <= req_vld_nx;
      owner_ls  <= owner_ls_nx;
      cnt       <= cnt_nx;
      if (fwd && !owner_ls) if_rdata_q <= mem_rdata;
      if (fwd &&  owner_ls) ls_rdata_q <= mem_rdata;
    end
  end

  // Responses pass through in the cycle they arrive; the held copy covers every other cycle.
  assign if_gnt    = if_win;
  assign ls_gnt    = ls_win;
  assign if_rvalid = fwd && !owner_ls;
  assign ls_rvalid = fwd &&  owner_ls;
  assign if_rdata  = (fwd && !owner_ls) ? mem_rdata : if_rdata_q;
  assign ls_rdata  = (fwd &&  owner_ls) ? mem_rdata : ls_rdata_q;

  assign mem_req   = req_vld_q;
  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_be    = req_q.be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, BW = 4, SM = 4;
  localparam int VW = 138;

  logic          clk = 1'b0;
  logic          nreset;
  logic          if_req, ls_req, ls_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] if_addr, ls_addr;
  logic [DW-1:0] ls_wdata, mem_rdata;
  logic [BW-1:0] ls_be;
  logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .nreset(nreset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, tot_cnt = 0;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_rdata, ls_rdata,
            mem_req, mem_we, mem_addr, mem_wdata, mem_be};
  endfunction

  // Transaction model: busy phase (0 free, 1 request on the port, 2 awaiting response),
  // who owns it, its fields, the count of IF-blocking LS wins, and last data per unit.
  int            ph, mcnt;
  bit            m_ls, m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_ifr, m_lsr;
  logic [BW-1:0] m_be;

  function automatic int winner();
    if (!(ph == 0 || (ph == 2 && mem_rvalid))) return 0;
    if (ls_req && !(if_req && mcnt == SM)) return 2;
    if (if_req) return 1;
    return 0;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    int w;
    bit resp;
    logic [DW-1:0] ir, lr;
    if (!nreset) return '0;
    w    = winner();
    resp = (ph == 2) && mem_rvalid;
    ir   = (resp && !m_ls) ? mem_rdata : m_ifr;
    lr   = (resp &&  m_ls) ? mem_rdata : m_lsr;
    return {w == 1, w == 2, resp && !m_ls, resp && m_ls, ir, lr,
            m_req, m_we, m_addr, m_wdata, m_be};
  endfunction

  always @(posedge clk) begin
    int w;
    if (!nreset) begin
      ph = 0; mcnt = 0; m_ls = 0; m_req = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_be = '0; m_ifr = '0; m_lsr = '0;
    end else begin
      w = winner();
      if (ph == 2 && mem_rvalid) begin
        if (m_ls) m_lsr = mem_rdata; else m_ifr = mem_rdata;
        ph = 0;
      end else if (ph == 1 && mem_gnt) begin
        ph = 2; m_req = 0;
      end
      if (w == 2) begin
        mcnt = if_req ? ((mcnt + 1 > SM) ? SM : mcnt + 1) : 0;
        m_ls = 1; m_we = ls_we; m_addr = ls_addr; m_wdata = ls_wdata; m_be = ls_be;
      end else if (w == 1) begin
        mcnt = 0;
        m_ls = 0; m_we = 0; m_addr = if_addr; m_wdata = '0; m_be = '1;
      end
      if (w != 0) begin ph = 1; m_req = 1; end
    end
  end

  always @(negedge clk) chk("cycle", dut_vec(), exp_vec());

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Called in an ISSUE cycle: accept now, respond next cycle.
  task automatic serve(input logic [DW-1:0] d);
    mem_gnt = 1; step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = d; step();
    mem_rvalid = 0;
  endtask

  logic [5:0] seq;

  initial begin
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    nreset = 1; #1 nreset = 0;
    #1 chk("reset", dut_vec(), '0);
    step(); step(); nreset = 1;
    step();

    // IF-only fetch
    if_req = 1; if_addr = 32'h10;
    #2 chk("t1 gnt", {if_gnt, ls_gnt}, 2'b10);
    step(); if_req = 0;
    #2 chk("t1 issue", {mem_req, mem_we, mem_addr, mem_be}, {1'b1, 1'b0, 32'h10, 4'hF});
    mem_gnt = 1;
    step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #2 chk("t1 resp", {if_rvalid, ls_rvalid, if_rdata}, {1'b1, 1'b0, 32'hDEADBEEF});
    step(); mem_rvalid = 0; mem_rdata = '0;

    // simultaneous: LS store first, IF granted on the store ack
    if_req = 1; if_addr = 32'h40;
    ls_req = 1; ls_we = 1; ls_addr = 32'h20; ls_be = 4'h3; ls_wdata = 32'h12345678;
    #2 chk("t2 arb", {if_gnt, ls_gnt}, 2'b01);
    step(); ls_req = 0; ls_we = 0;
    #2 chk("t2 store", {mem_req, mem_we, mem_addr, mem_wdata, mem_be},
           {1'b1, 1'b1, 32'h20, 32'h12345678, 4'h3});
    mem_gnt = 1;
    step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = '0;
    #2 chk("t2 ack", {ls_rvalid, if_rvalid, if_gnt, ls_gnt}, 4'b1010);
    step(); mem_rvalid = 0; if_req = 0;
    #2 chk("t2 fetch", {mem_req, mem_we, mem_addr, mem_be}, {1'b1, 1'b0, 32'h40, 4'hF});
    serve(32'hA5A50001);

    // starvation: 4 LS grants, IF, then LS again
    if_req = 1; if_addr = 32'h80; ls_req = 1; ls_we = 0; ls_addr = 32'h100; ls_be = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #2 seq[i] = ls_gnt;
      chk("t3 onehot", {if_gnt, ls_gnt} == 2'b01 || {if_gnt, ls_gnt} == 2'b10, 1'b1);
      step(); mem_rvalid = 0;
      if (i == 5) begin ls_req = 0; if_req = 0; end
      mem_gnt = 1;
      step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'(i);
    end
    step(); mem_rvalid = 0;
    chk("t3 seq", seq, 6'b101111);

    // stall in ISSUE for 3 cycles with IF waiting
    ls_req = 1; ls_we = 1; ls_addr = 32'h200; ls_wdata = 32'hCAFEF00D; ls_be = 4'hC;
    #2 chk("t4 gnt", {if_gnt, ls_gnt}, 2'b01);
    step(); ls_req = 0; ls_we = 0; if_req = 1; if_addr = 32'h300;
    for (int k = 0; k < 3; k++) begin
      #2 chk("t4 hold", {mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_gnt, ls_gnt},
             {1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 4'hC, 2'b00});
      step();
    end
    serve(32'h4444);
    if_req = 0;
    serve(32'h5555);

    // spurious response while idle
    mem_rvalid = 1; mem_rdata = 32'h77;
    #2 chk("t5 spur", {if_rvalid, ls_rvalid, if_rdata, ls_rdata, mem_req},
           {2'b00, 32'h5555, 32'h4444, 1'b0});
    step(); mem_rvalid = 0; if_req = 1; if_addr = 32'h500;
    #2 chk("t5 idle", {if_gnt, mem_req}, 2'b10);
    step(); if_req = 0;
    serve(32'h66);

    // reset during WAIT
    ls_req = 1; ls_we = 0; ls_addr = 32'h600; ls_be = 4'hF;
    step(); ls_req = 0; mem_gnt = 1;
    step(); mem_gnt = 0; ls_req = 1; ls_addr = 32'h700;
    #2 nreset = 0;
    #1 chk("t6 rst", dut_vec(), '0);
    step(); step(); nreset = 1;
    #2 chk("t6 regrant", {ls_gnt, if_gnt}, 2'b10);
    step(); ls_req = 0;
    #2 chk("t6 issue", {mem_req, mem_addr}, {1'b1, 32'h700});
    serve(32'h88);
    step();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between the instruction-fetch unit (IF) and the load/store unit (LS).
- Sits between the cpu core's fetch/LSU request interfaces and the unified memory, inside the cpu hierarchy.
- Keeps one transaction outstanding at a time. Response data is routed back to the unit that owns the transaction.
- LS has priority; a starvation counter guarantees forward progress for IF.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_MAX, 4, maximum consecutive LS grants while IF is pending before IF is forced to win (1..15).

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  one-cycle grant pulse to IF
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DW  fetch data
- ls_req  in  1  load/store request; held until ls_gnt
- ls_we  in  1  1 = store
- ls_addr  in  AW  load/store address
- ls_wdata  in  DW  store data
- ls_be  in  DW/8  byte enables
- ls_gnt  out  1  one-cycle grant pulse to LS
- ls_rvalid  out  1  load data valid, or store acknowledge
- ls_rdata  out  DW  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_be  out  DW/8  memory byte enables
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory response, for reads and writes
- mem_rdata  in  DW  memory read data

Behaviour:
- Clock and reset: one clock, clk. nreset is asynchronous and active-low.
- Reset state:
  - FSM in IDLE; owner = IF; starvation counter = 0.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_be are all 0.
  - if_gnt and ls_gnt are 0.
  - if_rvalid and ls_rvalid are 0; rdata outputs are 0.
- States: IDLE, ISSUE, WAIT.
- Arbitration (combinational):
  - Evaluated in IDLE, and in WAIT during the cycle mem_rvalid=1.
  - Winner is LS if ls_req, unless if_req=1 and counter == STARVE_MAX; then IF wins.
  - If only if_req is asserted, IF wins. With no request there is no grant.
  - The winner's gnt is asserted combinationally in the arbitration cycle.
  - At the clock edge: request fields are latched into the mem_* registers, owner is recorded, and the FSM moves to ISSUE.
- Counter:
  - LS grant while if_req=1: counter +1, saturating at STARVE_MAX.
  - IF grant: counter resets to 0.
  - LS grant while if_req=0: counter resets to 0.
- IF requests: mem_we=0, mem_be = all ones, mem_wdata = 0.
- ISSUE:
  - mem_req=1 with stable fields.
  - On mem_gnt: mem_req is 0 the next cycle and the FSM goes to WAIT.
  - mem_gnt with mem_req=0 is ignored.
- WAIT:
  - On mem_rvalid, it is forwarded combinationally, same cycle, to the owner's rvalid. mem_rdata goes to the owner's rdata. The non-owner's rdata holds its last value.
  - In the same cycle, arbitration runs. A winner goes to ISSUE, giving back-to-back requests with a one-cycle mem_req gap. Otherwise the FSM goes to IDLE.
- mem_rvalid in IDLE or ISSUE is a protocol error; it is ignored and not forwarded.
- Latency: a request sampled in cycle N gets gnt in N and mem_req in N+1. With mem_gnt in N+1 and mem_rvalid in N+2, the response reaches the owner in N+2.
- Simultaneous requests: LS wins unless the starvation override applies. The loser is not granted and must keep its req high.
- A request dropped before its gnt is legal and produces no transaction.
- Reset asserted mid-transaction: the transaction is abandoned and all state returns to reset values immediately. The memory is reset in the same domain.

Test Plan:
- Reset, then IF-only fetch at address 0x10:
  - if_gnt at cycle N; mem_req=1, mem_addr=0x10, mem_we=0 at N+1.
  - With mem_gnt at N+1 and mem_rvalid (rdata 0xDEADBEEF) at N+2: if_rvalid=1, if_rdata=0xDEADBEEF at N+2; ls_rvalid=0.
- if_req and ls_req together, ls_we=1, ls_addr=0x20, ls_be=0x3:
  - ls_gnt first; mem_we=1, mem_be=0x3.
  - The store ack drives ls_rvalid. if_gnt is asserted in that same cycle and the IF request issues next.
- Starvation with STARVE_MAX=4, ls_req held high and if_req high throughout:
  - Exactly 4 LS grants, then an IF grant, then the counter restarts at 0.
- Memory stalls mem_gnt for 3 cycles in ISSUE:
  - mem_req and all mem_* fields stay constant; no new gnt is issued.
- Spurious mem_rvalid in IDLE:
  - No rvalid on either side; state stays IDLE.
- nreset driven low in WAIT:
  - All outputs are 0 asynchronously.
  - After release, a new ls_req is granted from IDLE normally.
